// File: rtl/isp_gamma_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : isp_gamma_prog_if
// Description : YUV stream plus configuration bus for the programmable gamma stage.
// Revision    : 1.0
// ============================================================================
interface isp_gamma_prog_if #(
    parameter int BITS     = 8,
    parameter int LUT_BITS = 8
);
    logic                in_href;
    logic                in_vsync;
    logic [BITS-1:0]     in_y;
    logic [BITS-1:0]     in_u;
    logic [BITS-1:0]     in_v;
    logic                out_href;
    logic                out_vsync;
    logic [BITS-1:0]     out_y;
    logic [BITS-1:0]     out_u;
    logic [BITS-1:0]     out_v;
    logic                cfg_wr_en;
    logic [LUT_BITS:0]   cfg_wr_addr;
    logic [BITS-1:0]     cfg_wr_data;
    logic                cfg_swap_req;
    logic                cfg_bypass;
    logic                cfg_swap_pending;
    logic                cfg_active_bank;

    modport master (
        output in_href, in_vsync, in_y, in_u, in_v,
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_swap_req, cfg_bypass,
        input  out_href, out_vsync, out_y, out_u, out_v,
        input  cfg_swap_pending, cfg_active_bank
    );

    modport slave (
        input  in_href, in_vsync, in_y, in_u, in_v,
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_swap_req, cfg_bypass,
        output out_href, out_vsync, out_y, out_u, out_v,
        output cfg_swap_pending, cfg_active_bank
    );
endinterface
`default_nettype wire

// File: rtl/isp_gamma_prog.sv
`default_nettype none
// ============================================================================
// Module      : isp_gamma_prog
// Description : Double-buffered, interpolated gamma LUT on Y; U/V delay-matched.
// Revision    : 1.0
// ============================================================================
module isp_gamma_prog #(
    parameter int BITS     = 8,
    parameter int LUT_BITS = 8
) (
    input  wire logic        pclk,
    input  wire logic        rst_n,
    isp_gamma_prog_if.slave  bus
);
    localparam int c_F     = BITS - LUT_BITS;
    localparam int c_FW    = (c_F > 0) ? c_F : 1;
    localparam int c_KNOTS = (1 << LUT_BITS) + 1;
    localparam int c_MAX   = (1 << BITS) - 1;

    function automatic logic [BITS-1:0] ident(input int i);
        int v;
        v = i << c_F;
        return (v > c_MAX) ? BITS'(c_MAX) : BITS'(v);
    endfunction

    logic [BITS-1:0]   tbl_q [2][c_KNOTS];
    logic              active_q, active_d;
    logic              pending_q, pending_d;

    logic [BITS-1:0]   a_q, b_q, y1_q, u1_q, v1_q;
    logic [c_FW-1:0]   frac_q;
    logic              href1_q, vsync1_q, byp1_q;

    logic              out_href_q, out_vsync_q;
    logic [BITS-1:0]   out_y_q, out_u_q, out_v_q;

    logic              w_fs;
    logic [LUT_BITS:0] w_idx0, w_idx1;
    logic [c_FW-1:0]   w_frac;
    logic [BITS-1:0]   w_interp, w_y2;

    assign w_fs   = bus.in_vsync & ~vsync1_q;
    assign w_idx0 = {1'b0, bus.in_y[BITS-1 -: LUT_BITS]};
    assign w_idx1 = w_idx0 + 1'b1;

    generate
        if (c_F > 0) begin : g_frac
            assign w_frac = bus.in_y[c_FW-1:0];
        end else begin : g_nofrac
            assign w_frac = '0;
        end
    endgenerate

    // A swap request coincident with the frame edge only arms the next edge.
    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        if (w_fs && pending_q) begin
            active_d  = ~active_q;
            pending_d = 1'b0;
        end else if (bus.cfg_swap_req) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    // Writes target the bank that is inactive before any swap on this edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_KNOTS; i++) begin
                tbl_q[0][i] <= ident(i);
                tbl_q[1][i] <= ident(i);
            end
        end else if (bus.cfg_wr_en && (int'(bus.cfg_wr_addr) < c_KNOTS)) begin
            tbl_q[~active_q][bus.cfg_wr_addr] <= bus.cfg_wr_data;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            frac_q   <= '0;
            y1_q     <= '0;
            u1_q     <= '0;
            v1_q     <= '0;
            href1_q  <= 1'b0;
            vsync1_q <= 1'b0;
            byp1_q   <= 1'b0;
        end else begin
            a_q      <= tbl_q[active_q][w_idx0];
            b_q      <= tbl_q[active_q][w_idx1];
            frac_q   <= w_frac;
            y1_q     <= bus.in_y;
            u1_q     <= bus.in_u;
            v1_q     <= bus.in_v;
            href1_q  <= bus.in_href;
            vsync1_q <= bus.in_vsync;
            byp1_q   <= bus.cfg_bypass;
        end
    end

    generate
        if (c_F > 0) begin : g_interp
            localparam int c_PW = BITS + c_F + 3;
            logic signed [c_PW-1:0] w_diff, w_prod, w_rnd, w_sum;
            assign w_diff = $signed(c_PW'(b_q)) - $signed(c_PW'(a_q));
            assign w_prod = w_diff * $signed(c_PW'(frac_q));
            assign w_rnd  = (w_prod + $signed(c_PW'(1 << (c_F - 1)))) >>> c_F;
            assign w_sum  = $signed(c_PW'(a_q)) + w_rnd;
            assign w_interp = (w_sum < 0) ? '0 :
                              (w_sum > $signed(c_PW'(c_MAX))) ? '1 : w_sum[BITS-1:0];
        end else begin : g_nointerp
            logic unused_nointerp;
            assign unused_nointerp = ^{b_q, frac_q};
            assign w_interp        = a_q;
        end
    endgenerate

    assign w_y2 = byp1_q ? y1_q : w_interp;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_href_q  <= 1'b0;
            out_vsync_q <= 1'b0;
            out_y_q     <= '0;
            out_u_q     <= '0;
            out_v_q     <= '0;
        end else begin
            out_href_q  <= href1_q;
            out_vsync_q <= vsync1_q;
            out_y_q     <= href1_q ? w_y2 : '0;
            out_u_q     <= href1_q ? u1_q : '0;
            out_v_q     <= href1_q ? v1_q : '0;
        end
    end

    assign bus.out_href         = out_href_q;
    assign bus.out_vsync        = out_vsync_q;
    assign bus.out_y            = out_y_q;
    assign bus.out_u            = out_u_q;
    assign bus.out_v            = out_v_q;
    assign bus.cfg_swap_pending = pending_q;
    assign bus.cfg_active_bank  = active_q;
endmodule
`default_nettype wire

// File: tb/tb_isp_gamma_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_isp_gamma_prog
// Description : Directed self-checking bench; DUT A is 10/8 bits, DUT B is 8/8 bits.
// Revision    : 1.0
// ============================================================================
module tb_isp_gamma_prog;
    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 pclk = ~pclk;

    isp_gamma_prog_if #(.BITS(10), .LUT_BITS(8)) ifa ();
    isp_gamma_prog_if #(.BITS(8),  .LUT_BITS(8)) ifb ();

    isp_gamma_prog #(.BITS(10), .LUT_BITS(8)) dut_a (.pclk(pclk), .rst_n(rst_n), .bus(ifa));
    isp_gamma_prog #(.BITS(8),  .LUT_BITS(8)) dut_b (.pclk(pclk), .rst_n(rst_n), .bus(ifb));

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle_all();
        ifa.in_href = 0; ifa.in_vsync = 0; ifa.in_y = 0; ifa.in_u = 0; ifa.in_v = 0;
        ifa.cfg_wr_en = 0; ifa.cfg_wr_addr = 0; ifa.cfg_wr_data = 0;
        ifa.cfg_swap_req = 0; ifa.cfg_bypass = 0;
        ifb.in_href = 0; ifb.in_vsync = 0; ifb.in_y = 0; ifb.in_u = 0; ifb.in_v = 0;
        ifb.cfg_wr_en = 0; ifb.cfg_wr_addr = 0; ifb.cfg_wr_data = 0;
        ifb.cfg_swap_req = 0; ifb.cfg_bypass = 0;
    endtask

    // One pixel in, returns once it has emerged on the outputs.
    task automatic a_pix(input int y);
        ifa.in_href = 1; ifa.in_y = 10'(y);
        step();
        ifa.in_href = 0;
        step();
    endtask

    task automatic b_pix(input int y);
        ifb.in_href = 1; ifb.in_y = 8'(y);
        step();
        ifb.in_href = 0;
        step();
    endtask

    task automatic a_wr(input int addr, input int data);
        ifa.cfg_wr_en = 1; ifa.cfg_wr_addr = 9'(addr); ifa.cfg_wr_data = 10'(data);
        step();
        ifa.cfg_wr_en = 0;
    endtask

    task automatic a_swap_req();
        ifa.cfg_swap_req = 1;
        step();
        ifa.cfg_swap_req = 0;
    endtask

    task automatic a_vs();
        ifa.in_vsync = 1;
        step();
        ifa.in_vsync = 0;
        step();
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 0;
        step();
        step();
        checks++;
        if (ifa.out_href !== 1'b0 || ifa.out_vsync !== 1'b0 || ifa.out_y !== 10'd0 ||
            ifa.out_u !== 10'd0 || ifa.out_v !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got href=%0b y=%0d u=%0d v=%0d expected all 0",
                     ifa.out_href, ifa.out_y, ifa.out_u, ifa.out_v);
        end
        checks++;
        if (ifa.cfg_active_bank !== 1'b0 || ifa.cfg_swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_bank: got bank=%0b pending=%0b expected 0/0",
                     ifa.cfg_active_bank, ifa.cfg_swap_pending);
        end
        rst_n = 1;
        step();
    endtask

    task automatic test_identity_ramp();
        int bad = 0;
        for (int i = 0; i <= 1020; i++) begin
            if (i <= 1019) begin
                ifa.in_href = 1; ifa.in_y = 10'(i);
            end else begin
                ifa.in_href = 0; ifa.in_y = 0;
            end
            step();
            if (i >= 1) begin
                checks++;
                if (ifa.out_href !== 1'b1 || int'(ifa.out_y) !== i - 1) begin
                    errors++;
                    if (bad < 5)
                        $display("FAIL ramp_y: got href=%0b y=%0d expected 1/%0d",
                                 ifa.out_href, ifa.out_y, i - 1);
                    bad++;
                end
            end
        end
        step();
    endtask

    task automatic test_interp_rising();
        int ys[3] = '{18, 16, 17};
        int ex[3] = '{150, 100, 125};
        a_wr(4, 100);
        a_wr(5, 200);
        a_pix(17);
        checks++;
        if (int'(ifa.out_y) !== 17) begin
            errors++;
            $display("FAIL active_untouched: got %0d expected 17", ifa.out_y);
        end
        a_swap_req();
        checks++;
        if (ifa.cfg_swap_pending !== 1'b1 || ifa.cfg_active_bank !== 1'b0) begin
            errors++;
            $display("FAIL pending_set: got pending=%0b bank=%0b expected 1/0",
                     ifa.cfg_swap_pending, ifa.cfg_active_bank);
        end
        a_vs();
        checks++;
        if (ifa.cfg_swap_pending !== 1'b0 || ifa.cfg_active_bank !== 1'b1) begin
            errors++;
            $display("FAIL swap_applied: got pending=%0b bank=%0b expected 0/1",
                     ifa.cfg_swap_pending, ifa.cfg_active_bank);
        end
        for (int i = 0; i < 3; i++) begin
            a_pix(ys[i]);
            checks++;
            if (int'(ifa.out_y) !== ex[i]) begin
                errors++;
                $display("FAIL rise_y%0d: got %0d expected %0d", ys[i], ifa.out_y, ex[i]);
            end
        end
    endtask

    task automatic test_interp_falling();
        int ys[2] = '{17, 19};
        int ex[2] = '{175, 125};
        a_wr(4, 200);
        a_wr(5, 100);
        a_swap_req();
        a_vs();
        for (int i = 0; i < 2; i++) begin
            a_pix(ys[i]);
            checks++;
            if (int'(ifa.out_y) !== ex[i]) begin
                errors++;
                $display("FAIL fall_y%0d: got %0d expected %0d", ys[i], ifa.out_y, ex[i]);
            end
        end
    endtask

    task automatic test_swap_timing();
        a_swap_req();
        a_pix(17);
        checks++;
        if (int'(ifa.out_y) !== 175 || ifa.cfg_swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL midframe_hold: got y=%0d pending=%0b expected 175/1",
                     ifa.out_y, ifa.cfg_swap_pending);
        end
        // Pixel on the frame-edge cycle still sees the old bank; the next one the new.
        ifa.in_vsync = 1; ifa.in_href = 1; ifa.in_y = 10'd17;
        step();
        step();
        checks++;
        if (int'(ifa.out_y) !== 175) begin
            errors++;
            $display("FAIL fs_pixel_old: got %0d expected 175", ifa.out_y);
        end
        ifa.in_href = 0;
        step();
        checks++;
        if (int'(ifa.out_y) !== 125 || ifa.cfg_active_bank !== 1'b1 ||
            ifa.cfg_swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL first_pixel_new: got y=%0d bank=%0b pending=%0b expected 125/1/0",
                     ifa.out_y, ifa.cfg_active_bank, ifa.cfg_swap_pending);
        end
        ifa.in_vsync = 0;
        step();
        ifa.in_vsync = 1; ifa.cfg_swap_req = 1;
        step();
        ifa.cfg_swap_req = 0;
        checks++;
        if (ifa.cfg_active_bank !== 1'b1 || ifa.cfg_swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL req_on_fs: got bank=%0b pending=%0b expected 1/1",
                     ifa.cfg_active_bank, ifa.cfg_swap_pending);
        end
        ifa.in_vsync = 0;
        step();
        a_vs();
        checks++;
        if (ifa.cfg_active_bank !== 1'b0 || ifa.cfg_swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL req_on_fs_next: got bank=%0b pending=%0b expected 0/0",
                     ifa.cfg_active_bank, ifa.cfg_swap_pending);
        end
    endtask

    task automatic test_write_edges();
        int ys[3] = '{24, 5, 17};
        int ex[3] = '{300, 5, 125};
        a_wr(257, 999);
        a_swap_req();
        ifa.in_vsync = 1;
        ifa.cfg_wr_en = 1; ifa.cfg_wr_addr = 9'd6; ifa.cfg_wr_data = 10'd300;
        step();
        ifa.cfg_wr_en = 0; ifa.in_vsync = 0;
        step();
        checks++;
        if (ifa.cfg_active_bank !== 1'b1) begin
            errors++;
            $display("FAIL wr_swap_bank: got %0b expected 1", ifa.cfg_active_bank);
        end
        for (int i = 0; i < 3; i++) begin
            a_pix(ys[i]);
            checks++;
            if (int'(ifa.out_y) !== ex[i]) begin
                errors++;
                $display("FAIL wr_edge_y%0d: got %0d expected %0d", ys[i], ifa.out_y, ex[i]);
            end
        end
    endtask

    task automatic test_narrow_bypass_gate();
        ifb.cfg_wr_en = 1; ifb.cfg_wr_addr = 9'd128; ifb.cfg_wr_data = 8'd200;
        step();
        ifb.cfg_wr_en = 0; ifb.cfg_swap_req = 1;
        step();
        ifb.cfg_swap_req = 0; ifb.in_vsync = 1;
        step();
        ifb.in_vsync = 0;
        step();
        b_pix(128);
        checks++;
        if (int'(ifb.out_y) !== 200 || ifb.cfg_active_bank !== 1'b1) begin
            errors++;
            $display("FAIL narrow_128: got y=%0d bank=%0b expected 200/1", ifb.out_y, ifb.cfg_active_bank);
        end
        b_pix(129);
        checks++;
        if (int'(ifb.out_y) !== 129) begin
            errors++;
            $display("FAIL narrow_129: got %0d expected 129", ifb.out_y);
        end
        ifb.cfg_bypass = 1;
        b_pix(128);
        ifb.cfg_bypass = 0;
        checks++;
        if (int'(ifb.out_y) !== 128) begin
            errors++;
            $display("FAIL narrow_bypass: got %0d expected 128", ifb.out_y);
        end
        ifb.in_href = 0; ifb.in_y = 8'd77; ifb.in_u = 8'd5; ifb.in_v = 8'd6;
        step();
        step();
        checks++;
        if (ifb.out_href !== 1'b0 || ifb.out_y !== 8'd0 || ifb.out_u !== 8'd0 || ifb.out_v !== 8'd0) begin
            errors++;
            $display("FAIL href0_gate: got href=%0b y=%0d u=%0d v=%0d expected all 0",
                     ifb.out_href, ifb.out_y, ifb.out_u, ifb.out_v);
        end
        ifb.in_y = 0; ifb.in_u = 0; ifb.in_v = 0;
        ifa.cfg_bypass = 1; ifa.in_u = 10'd33; ifa.in_v = 10'd44;
        a_pix(17);
        ifa.cfg_bypass = 0; ifa.in_u = 0; ifa.in_v = 0;
        checks++;
        if (int'(ifa.out_y) !== 17 || int'(ifa.out_u) !== 33 || int'(ifa.out_v) !== 44) begin
            errors++;
            $display("FAIL bypass_uv: got y=%0d u=%0d v=%0d expected 17/33/44",
                     ifa.out_y, ifa.out_u, ifa.out_v);
        end
        ifa.in_vsync = 1;
        step();
        step();
        checks++;
        if (ifa.out_vsync !== 1'b1 || ifa.out_y !== 10'd0) begin
            errors++;
            $display("FAIL vsync_delay: got vsync=%0b y=%0d expected 1/0", ifa.out_vsync, ifa.out_y);
        end
        ifa.in_vsync = 0;
        step();
        step();
    endtask

    task automatic test_reset_midline();
        a_swap_req();
        ifa.in_href = 1; ifa.in_y = 10'd500; ifa.in_u = 10'd1; ifa.in_v = 10'd2;
        step();
        step();
        checks++;
        if (ifa.out_href !== 1'b1 || int'(ifa.out_y) !== 500 || ifa.cfg_swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got href=%0b y=%0d pending=%0b expected 1/500/1",
                     ifa.out_href, ifa.out_y, ifa.cfg_swap_pending);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (ifa.out_href !== 1'b0 || ifa.out_y !== 10'd0 || ifa.out_u !== 10'd0 ||
            ifa.cfg_active_bank !== 1'b0 || ifa.cfg_swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got href=%0b y=%0d u=%0d bank=%0b pending=%0b expected all 0",
                     ifa.out_href, ifa.out_y, ifa.out_u, ifa.cfg_active_bank, ifa.cfg_swap_pending);
        end
        step();
        idle_all();
        rst_n = 1;
        step();
        a_pix(17);
        checks++;
        if (int'(ifa.out_y) !== 17 || ifa.cfg_active_bank !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_identity: got y=%0d bank=%0b expected 17/0",
                     ifa.out_y, ifa.cfg_active_bank);
        end
        b_pix(128);
        checks++;
        if (int'(ifb.out_y) !== 128 || ifb.cfg_active_bank !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_narrow: got y=%0d bank=%0b expected 128/0",
                     ifb.out_y, ifb.cfg_active_bank);
        end
    endtask

    initial begin
        test_reset();
        test_identity_ramp();
        test_interp_rising();
        test_interp_falling();
        test_swap_timing();
        test_write_edges();
        test_narrow_bypass_gate();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
